output_sram_arbiter: RTL
========================

OUTPUT_SRAM_ARBITER -- requirements
Module: output_sram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requester ports.
REQ-002 Parameter TIMEOUT, default 16, maximum WAIT cycles before the block aborts a transaction.
REQ-003 Parameter NUM_ROWS, default 6, number of populated SRAM rows; addr[13:11] must be below this value.
REQ-004 clock  input  1  clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester request; held high until the matching ack.
REQ-007 req_we  input  NUM_REQ  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  input  NUM_REQ x 14  per-requester word address: [13:11] selects the row, [10:0] the word.
REQ-009 req_wdata  input  NUM_REQ x 64  per-requester write data.
REQ-010 ack  output  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-011 err  output  1  valid with ack; 1 = range error or timeout.
REQ-012 rdata  output  64  read data, valid with ack for reads.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 w_en, r_en  output  1 each  to SRAM controller; one-cycle issue pulses.
REQ-015 w_addr, r_addr  output  32 each  both carry the latched 14-bit address, zero-extended.
REQ-016 w_d  output  64  latched write data.
REQ-017 w_done, d_ready  input  1 each  completion strobes from the SRAM controller.
REQ-018 r_d  input  64  read data from the SRAM controller.

Function
REQ-019 The FSM shall have four states: IDLE, ISSUE, WAIT, RESP; all outputs shall be registered.
REQ-020 In IDLE with any req high, the block shall grant round-robin, starting from index (last_grant+1) mod NUM_REQ.
REQ-021 On grant, the block shall latch the winner's index, we, addr and wdata, and record last_grant = winner.
REQ-022 On grant with addr[13:11] >= NUM_ROWS, the FSM shall go IDLE->RESP with err=1 and shall not issue to the controller.
REQ-023 On a valid grant, the FSM shall go IDLE->ISSUE.
REQ-024 In ISSUE, the block shall assert exactly one of w_en/r_en (by we) for one cycle, then go to WAIT.
REQ-025 w_en and r_en shall never be high together and never high outside ISSUE.
REQ-026 WAIT shall exit to RESP on w_done (write) or d_ready (read).
REQ-027 On a read completion, the block shall capture r_d into rdata on the same edge.
REQ-028 A strobe of the wrong type in WAIT shall be ignored.
REQ-029 A 5-bit wait counter shall clear on entry to WAIT and increment each WAIT cycle.
REQ-030 When the counter reaches TIMEOUT with no completion, the FSM shall go to RESP with err=1 and rdata=0.
REQ-031 In RESP, the block shall pulse ack[winner] for one cycle, with err/rdata valid, then return to IDLE.
REQ-032 err and rdata shall hold their values until the next RESP.
REQ-033 Nominal latency shall be 4 cycles: req sampled in IDLE at cycle 0, ISSUE at cycle 1, controller strobe at cycle 3, ack at cycle 4.
REQ-034 A range-error ack shall occur at cycle 1.
REQ-035 Throughput shall be at most one transaction per 5 cycles.
REQ-036 A requester may keep req high after its ack to present a new transaction; round-robin still applies.
REQ-037 Changes on req inputs of non-granted ports shall not affect the transaction in flight.

Reset
REQ-038 During reset, the block shall drive ack=0, err=0, rdata=0, busy=0, w_en=r_en=0, w_addr=r_addr=0, w_d=0.
REQ-039 Reset shall set state=IDLE, last_grant=NUM_REQ-1 (so port 0 wins first), and the wait counter to 0.
REQ-040 Reset asserted mid-transaction shall abandon it with no ack; later controller strobes shall be ignored in IDLE.

Verification
REQ-041 Write: port 2 writes addr 0x0805, data 0xDEADBEEF_01234567 -> w_en pulse at cycle 1 with w_addr=0x805; with the controller model, ack[2] at cycle 4, err=0.
REQ-042 Readback: port 1 reads 0x0805 after REQ-041 -> r_en pulse at cycle 1; ack[1] at cycle 4 with rdata=0xDEADBEEF_01234567.
REQ-043 Fairness: all 4 ports request continuously after reset -> grant order 0,1,2,3,0; acks 5 cycles apart.
REQ-044 Range error: port 0 requests addr 0x3000 (row 6) -> no w_en/r_en; ack[0] with err=1 at cycle 1.
REQ-045 Timeout: the controller model never strobes -> ack with err=1 after TIMEOUT WAIT cycles; the next request proceeds normally.
REQ-046 Mid-operation reset: reset in WAIT -> no ack; all outputs at reset values next cycle; port 0 wins the next grant.

Source files
------------

// File: rtl/output_sram_arbiter_if.sv
// output_sram_arbiter_if: requester-side and SRAM-controller-side signals of the arbiter
//   req/req_we/req_addr/req_wdata  per-requester request, direction, 14-bit word address, write data
//   ack/err/rdata                  one-hot completion pulse, error flag, read data
//   busy                           arbiter not idle
//   w_en/r_en/w_addr/r_addr/w_d    issue pulses, address and write data to the SRAM controller
//   w_done/d_ready/r_d             completion strobes and read data from the SRAM controller
interface output_sram_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req, req_we, ack;
   logic [NUM_REQ-1:0][13:0] req_addr;
   logic [NUM_REQ-1:0][63:0] req_wdata;
   logic                     err, busy, w_en, r_en, w_done, d_ready;
   logic [63:0]              rdata, w_d, r_d;
   logic [31:0]              w_addr, r_addr;
   modport slave (
      input  req, req_we, req_addr, req_wdata, w_done, d_ready, r_d,
      output ack, err, rdata, busy, w_en, r_en, w_addr, r_addr, w_d
   );
   modport master (
      output req, req_we, req_addr, req_wdata, w_done, d_ready, r_d,
      input  ack, err, rdata, busy, w_en, r_en, w_addr, r_addr, w_d
   );
endinterface

// File: rtl/output_sram_arbiter.sv
// output_sram_arbiter: round-robin arbiter of NUM_REQ requesters onto one SRAM controller
//   clock  rising-edge clock
//   reset  synchronous active-high reset
//   bus    output_sram_arbiter_if slave modport (requester and controller signals, busy)
module output_sram_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int TIMEOUT  = 16,
   parameter int NUM_ROWS = 6
) (
   input logic                  clock,
   input logic                  reset,
   output_sram_arbiter_if.slave bus
);
   localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t             state_q, state_d;
   logic [IW-1:0]      last_q, last_d, win_q, win_d, pick;
   logic               found, bad_row, done, we_q, we_d;
   logic [13:0]        addr_q, addr_d;
   logic [63:0]        wdata_q, wdata_d, rdata_q, rdata_d;
   logic [4:0]         cnt_q, cnt_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               err_q, err_d, busy_q, busy_d, w_en_q, w_en_d, r_en_q, r_en_d;
   // search starts one past the previous winner so every port gets a turn
   always_comb begin
      pick  = last_q;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!found && bus.req[(int'(last_q) + i) % NUM_REQ]) begin
            pick  = IW'((int'(last_q) + i) % NUM_REQ);
            found = 1'b1;
         end
      end
   end
   assign bad_row = 32'(bus.req_addr[pick][13:11]) >= NUM_ROWS;
   // only the strobe matching the latched direction completes the transfer
   assign done = we_q ? bus.w_done : bus.d_ready;
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      win_d   = win_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = state_q == WAIT ? cnt_q + 5'd1 : 5'd0;
      case (state_q)
         IDLE: if (found) begin
            state_d = bad_row ? RESP : ISSUE;
            last_d  = pick;
            win_d   = pick;
            we_d    = bus.req_we[pick];
            addr_d  = bus.req_addr[pick];
            wdata_d = bus.req_wdata[pick];
            if (bad_row) begin
               err_d   = 1'b1;
               rdata_d = '0;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: if (done || cnt_q == 5'(TIMEOUT - 1)) begin
            state_d = RESP;
            err_d   = !done;
            rdata_d = (done && !we_q) ? bus.r_d : '0;
         end
         default: state_d = IDLE;
      endcase
      // outputs are registered from the next state so they line up with it
      ack_d  = state_d == RESP ? NUM_REQ'(1) << win_d : '0;
      busy_d = state_d != IDLE;
      w_en_d = state_d == ISSUE && we_d;
      r_en_d = state_d == ISSUE && !we_d;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= IW'(NUM_REQ - 1);
         win_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         w_en_q  <= 1'b0;
         r_en_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         w_en_q  <= w_en_d;
         r_en_q  <= r_en_d;
      end
   end
   assign bus.ack    = ack_q;
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;
   assign bus.busy   = busy_q;
   assign bus.w_en   = w_en_q;
   assign bus.r_en   = r_en_q;
   assign bus.w_addr = {18'd0, addr_q};
   assign bus.r_addr = {18'd0, addr_q};
   assign bus.w_d    = wdata_q;
endmodule
